// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared types, limits and round-constant helpers for the Ascon permutation
package ascon_pkg;

  typedef logic [63:0] ascon_word_t;
  typedef ascon_word_t [4:0] ascon_state_t;

  localparam int ASCON_MAX_ROUNDS = 12;

  typedef enum logic {
    S_IDLE,
    S_PERM
  } perm_state_e;

  // Constant for round index idx of the 12-round schedule: high nibble 15-idx, low nibble idx.
  function automatic logic [7:0] ascon_rc(input logic [3:0] idx);
    return {4'hf - idx, idx};
  endfunction

  function automatic ascon_word_t ascon_rotr(input ascon_word_t x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

endpackage

// File: rtl/ascon_perm_engine_if.sv
// rtl/ascon_perm_engine_if.sv - host word access and permutation control bundle (clear_i with ASCON_PERM_CLEAR_EN)
interface ascon_perm_engine_if;

  logic        start_perm_i;
  logic [3:0]  rounds_i;
  logic [2:0]  word_sel_i;
  logic [63:0] data_i;
  logic        write_en_i;
  logic        xor_en_i;
`ifdef ASCON_PERM_CLEAR_EN
  logic        clear_i;
`endif
  logic [63:0] data_o;
  logic        busy_o;
  logic        perm_done_o;

`ifdef ASCON_PERM_CLEAR_EN
  modport slave (
    input  start_perm_i, rounds_i, word_sel_i, data_i, write_en_i, xor_en_i, clear_i,
    output data_o, busy_o, perm_done_o
  );
  modport master (
    output start_perm_i, rounds_i, word_sel_i, data_i, write_en_i, xor_en_i, clear_i,
    input  data_o, busy_o, perm_done_o
  );
`else
  modport slave (
    input  start_perm_i, rounds_i, word_sel_i, data_i, write_en_i, xor_en_i,
    output data_o, busy_o, perm_done_o
  );
  modport master (
    output start_perm_i, rounds_i, word_sel_i, data_i, write_en_i, xor_en_i,
    input  data_o, busy_o, perm_done_o
  );
`endif

endinterface

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational Ascon round (constant add, bitsliced S-box, linear layer)
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t state_i,
  input  logic [3:0]   idx_i,
  input  logic         bypass_i,
  output ascon_state_t state_o
);

  ascon_word_t  x0, x1, x2, x3, x4;
  ascon_word_t  t0, t1, t2, t3, t4;
  ascon_state_t round_out;

  always_comb begin
    x0 = state_i[0];
    x1 = state_i[1];
    x2 = state_i[2] ^ {56'd0, ascon_rc(idx_i)};
    x3 = state_i[3];
    x4 = state_i[4];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    round_out[0] = x0 ^ ascon_rotr(x0, 19) ^ ascon_rotr(x0, 28);
    round_out[1] = x1 ^ ascon_rotr(x1, 61) ^ ascon_rotr(x1, 39);
    round_out[2] = x2 ^ ascon_rotr(x2, 1)  ^ ascon_rotr(x2, 6);
    round_out[3] = x3 ^ ascon_rotr(x3, 10) ^ ascon_rotr(x3, 17);
    round_out[4] = x4 ^ ascon_rotr(x4, 7)  ^ ascon_rotr(x4, 41);
  end

  assign state_o = bypass_i ? state_i : round_out;

endmodule

// File: rtl/ascon_perm_engine.sv
// rtl/ascon_perm_engine.sv - Ascon-p[rnd] engine, UNROLL rounds per clock; ASCON_PERM_CLEAR_EN adds clear_i
module ascon_perm_engine
  import ascon_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input logic                clk,
  input logic                rst,
  ascon_perm_engine_if.slave bus
);

  localparam logic [3:0] UNROLL_W = 4'(UNROLL);
  localparam logic [3:0] MAX_RND  = 4'(ASCON_MAX_ROUNDS);

  perm_state_e  fsm_q, fsm_d;
  ascon_state_t state_q, state_d;
  logic [3:0]   rem_q, rem_d;
  logic [3:0]   idx_q, idx_d;
  logic         done_q, done_d;
  logic         clear_req;
  logic [3:0]   nr;
  logic [3:0]   step;
  logic [63:0]  rd_data;
  ascon_state_t chain [0:UNROLL];

`ifdef ASCON_PERM_CLEAR_EN
  assign clear_req = bus.clear_i;
`else
  assign clear_req = 1'b0;
`endif

  assign nr   = (bus.rounds_i > MAX_RND) ? MAX_RND : bus.rounds_i;
  assign step = (rem_q < UNROLL_W) ? rem_q : UNROLL_W;

  // Stages past the remaining round count pass the state through unchanged.
  assign chain[0] = state_q;
  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    ascon_round u_round (
      .state_i  (chain[j]),
      .idx_i    (idx_q + 4'(j)),
      .bypass_i (4'(j) >= rem_q),
      .state_o  (chain[j+1])
    );
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (fsm_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d = '0;
        end else begin
          for (int w = 0; w < 5; w++) begin
            if (bus.word_sel_i == 3'(w)) begin
              if (bus.write_en_i) begin
                state_d[w] = bus.data_i;
              end else if (bus.xor_en_i) begin
                state_d[w] = state_q[w] ^ bus.data_i;
              end
            end
          end
          if (bus.start_perm_i) begin
            if (nr == 4'd0) begin
              done_d = 1'b1;
            end else begin
              fsm_d = S_PERM;
              rem_d = nr;
              idx_d = MAX_RND - nr;
            end
          end
        end
      end
      S_PERM: begin
        if (clear_req) begin
          fsm_d   = S_IDLE;
          state_d = '0;
          rem_d   = '0;
          idx_d   = '0;
        end else begin
          state_d = chain[UNROLL];
          rem_d   = rem_q - step;
          idx_d   = idx_q + step;
          if (rem_q <= UNROLL_W) begin
            fsm_d  = S_IDLE;
            done_d = 1'b1;
          end
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    rd_data = '0;
    case (bus.word_sel_i)
      3'd0:    rd_data = state_q[0];
      3'd1:    rd_data = state_q[1];
      3'd2:    rd_data = state_q[2];
      3'd3:    rd_data = state_q[3];
      3'd4:    rd_data = state_q[4];
      default: rd_data = '0;
    endcase
  end

  assign bus.data_o      = rd_data;
  assign bus.busy_o      = (fsm_q == S_PERM);
  assign bus.perm_done_o = done_q;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// tb/tb_ascon_perm_engine.sv - directed bench for ascon_perm_engine at UNROLL=1 and UNROLL=3
module tb_ascon_perm_engine;
  import ascon_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  rounds;
  logic [2:0]  sel;
  logic [63:0] din;
  logic        we;
  logic        xe;
`ifdef ASCON_PERM_CLEAR_EN
  logic        clr;
`endif

  always #5 clk = ~clk;

  ascon_perm_engine_if bus1 ();
  ascon_perm_engine_if bus3 ();

  assign bus1.start_perm_i = start;
  assign bus1.rounds_i     = rounds;
  assign bus1.word_sel_i   = sel;
  assign bus1.data_i       = din;
  assign bus1.write_en_i   = we;
  assign bus1.xor_en_i     = xe;
  assign bus3.start_perm_i = start;
  assign bus3.rounds_i     = rounds;
  assign bus3.word_sel_i   = sel;
  assign bus3.data_i       = din;
  assign bus3.write_en_i   = we;
  assign bus3.xor_en_i     = xe;
`ifdef ASCON_PERM_CLEAR_EN
  assign bus1.clear_i = clr;
  assign bus3.clear_i = clr;
`endif

  ascon_perm_engine #(.UNROLL(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  ascon_perm_engine #(.UNROLL(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  // Table-driven model: S-box applied column by column, x0 as the column MSB.
  function automatic ascon_state_t ref_perm(input ascon_state_t s_in, input int nr);
    ascon_state_t s;
    logic [4:0]   col;
    int           idx;
    s = s_in;
    for (int r = 0; r < nr; r++) begin
      idx = 12 - nr + r;
      s[2][7:0] = s[2][7:0] ^ 8'(((15 - idx) << 4) | idx);
      for (int b = 0; b < 64; b++) begin
        col = SBOX[{s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]}];
        {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]} = col;
      end
      s[0] = s[0] ^ rr(s[0], 19) ^ rr(s[0], 28);
      s[1] = s[1] ^ rr(s[1], 61) ^ rr(s[1], 39);
      s[2] = s[2] ^ rr(s[2], 1)  ^ rr(s[2], 6);
      s[3] = s[3] ^ rr(s[3], 10) ^ rr(s[3], 17);
      s[4] = s[4] ^ rr(s[4], 7)  ^ rr(s[4], 41);
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input ascon_state_t s);
    for (int w = 0; w < 5; w++) begin
      sel = 3'(w);
      din = s[w];
      we  = 1'b1;
      tick();
    end
    we = 1'b0;
  endtask

  task automatic read_all(output ascon_state_t s1, output ascon_state_t s3);
    for (int w = 0; w < 5; w++) begin
      sel = 3'(w);
      #1;
      s1[w] = bus1.data_o;
      s3[w] = bus3.data_o;
    end
  endtask

  task automatic chk_state(input string tag, input ascon_state_t s1, input ascon_state_t s3,
                           input ascon_state_t exp);
    for (int w = 0; w < 5; w++) begin
      chk($sformatf("%s_u1_x%0d", tag, w), s1[w], exp[w]);
      chk($sformatf("%s_u3_x%0d", tag, w), s3[w], exp[w]);
    end
  endtask

  // Pulses start for one edge, then watches 20 cycles; optionally injects write x1 + start while busy.
  task automatic do_perm(input logic [3:0] nr, input int inject,
                         output int c1, output int c3, output int n1, output int n3);
    c1 = -1; c3 = -1; n1 = 0; n3 = 0;
    rounds = nr;
    start  = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      start = 1'b0;
      we    = 1'b0;
      if (cyc == 0) chk("busy_after_start", {63'd0, bus1.busy_o}, {63'd0, nr != 4'd0});
      if (cyc == inject) begin
        sel   = 3'd1;
        din   = 64'hDEAD;
        we    = 1'b1;
        start = 1'b1;
      end
      if (bus1.perm_done_o) begin
        n1++;
        if (c1 < 0) begin
          c1 = cyc;
          chk("busy_low_at_done", {63'd0, bus1.busy_o}, 64'd0);
        end
      end
      if (bus3.perm_done_o) begin
        n3++;
        if (c3 < 0) c3 = cyc;
      end
    end
  endtask

  initial begin
    ascon_state_t zero_st, cur, exp, s1, s3, iv, kat;
    int c1, c3, n1, n3;

    zero_st = '0;
    rst = 1'b1; start = 1'b0; rounds = '0; sel = '0; din = '0; we = 1'b0; xe = 1'b0;
`ifdef ASCON_PERM_CLEAR_EN
    clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    read_all(s1, s3);
    chk_state("reset", s1, s3, zero_st);
    chk("reset_busy", {63'd0, bus1.busy_o}, 64'd0);
    chk("reset_done", {63'd0, bus1.perm_done_o}, 64'd0);

    load(zero_st);
    do_perm(4'd12, -1, c1, c3, n1, n3);
    chk("p12_lat_u1", 64'(c1), 64'd12);
    chk("p12_lat_u3", 64'(c3), 64'd4);
    chk("p12_pulses", 64'(n1), 64'd1);
    read_all(s1, s3);
    exp = ref_perm(zero_st, 12);
    chk_state("p12_zero", s1, s3, exp);

    cur = exp;
    do_perm(4'd8, -1, c1, c3, n1, n3);
    chk("p8_lat_u1", 64'(c1), 64'd8);
    chk("p8_lat_u3", 64'(c3), 64'd3);
    read_all(s1, s3);
    exp = ref_perm(cur, 8);
    chk_state("p8", s1, s3, exp);

    cur = exp;
    do_perm(4'd6, -1, c1, c3, n1, n3);
    chk("p6_lat_u3", 64'(c3), 64'd2);
    read_all(s1, s3);
    chk_state("p6", s1, s3, ref_perm(cur, 6));

    iv  = '0;
    iv[0] = 64'h00400c0000000100;
    kat[0] = 64'hee9398aadb67f03d;
    kat[1] = 64'h8bb21831c60f1002;
    kat[2] = 64'hb48a92db98d5da62;
    kat[3] = 64'h43189921b8f8e3e8;
    kat[4] = 64'h348fa5c9d525e140;
    load(iv);
    do_perm(4'd12, -1, c1, c3, n1, n3);
    read_all(s1, s3);
    chk_state("hash_iv_kat", s1, s3, kat);

    sel = 3'd2; din = 64'hFFFF_0000_FFFF_0000; we = 1'b1;
    tick();
    we = 1'b0; xe = 1'b1; din = 64'h0F0F_0F0F_0F0F_0F0F;
    tick();
    xe = 1'b0;
    chk("xor_x2", bus1.data_o, 64'hF0F0_0F0F_F0F0_0F0F);
    we = 1'b1; xe = 1'b1; din = 64'h0123_4567_89AB_CDEF;
    tick();
    we = 1'b0; xe = 1'b0;
    chk("write_wins", bus3.data_o, 64'h0123_4567_89AB_CDEF);

    cur = kat;
    cur[2] = 64'h0123_4567_89AB_CDEF;
    sel = 3'd5; din = '1; we = 1'b1;
    tick();
    we = 1'b0;
    chk("sel5_reads_zero", bus1.data_o, 64'd0);
    read_all(s1, s3);
    chk_state("sel5_write_ignored", s1, s3, cur);

    do_perm(4'd12, 1, c1, c3, n1, n3);
    chk("busy_inject_pulses_u1", 64'(n1), 64'd1);
    chk("busy_inject_pulses_u3", 64'(n3), 64'd1);
    chk("busy_inject_lat", 64'(c1), 64'd12);
    read_all(s1, s3);
    exp = ref_perm(cur, 12);
    chk_state("busy_inject", s1, s3, exp);

    cur = exp;
    do_perm(4'd0, -1, c1, c3, n1, n3);
    chk("r0_lat_u1", 64'(c1), 64'd0);
    chk("r0_lat_u3", 64'(c3), 64'd0);
    chk("r0_pulses", 64'(n1), 64'd1);
    read_all(s1, s3);
    chk_state("r0_unchanged", s1, s3, cur);

    do_perm(4'd15, -1, c1, c3, n1, n3);
    chk("r15_lat_u1", 64'(c1), 64'd12);
    chk("r15_lat_u3", 64'(c3), 64'd4);
    read_all(s1, s3);
    exp = ref_perm(cur, 12);
    chk_state("r15_as_12", s1, s3, exp);

    rounds = 4'd12; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", {63'd0, bus1.busy_o}, 64'd0);
    read_all(s1, s3);
    chk_state("rst_mid", s1, s3, zero_st);
    tick();
    rst = 1'b0;
    n1 = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus1.perm_done_o || bus3.perm_done_o) n1++;
    end
    chk("rst_mid_no_done", 64'(n1), 64'd0);

`ifdef ASCON_PERM_CLEAR_EN
    load(kat);
    rounds = 4'd12; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_mid_busy", {63'd0, bus1.busy_o}, 64'd0);
    chk("clr_mid_done", {63'd0, bus1.perm_done_o}, 64'd0);
    read_all(s1, s3);
    chk_state("clr_mid", s1, s3, zero_st);
    n1 = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus1.perm_done_o || bus3.perm_done_o) n1++;
    end
    chk("clr_mid_no_done", 64'(n1), 64'd0);

    load(kat);
    clr = 1'b1; we = 1'b1; sel = 3'd0; din = '1; start = 1'b1; rounds = 4'd0;
    tick();
    clr = 1'b0; we = 1'b0; start = 1'b0;
    chk("clr_idle_done", {63'd0, bus1.perm_done_o}, 64'd0);
    read_all(s1, s3);
    chk_state("clr_idle", s1, s3, zero_st);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
